// File: rtl/lns_lut_arbiter.sv
// Two-requester arbiter in front of a shared combinational Gaussian-log LUT (F_3/F_4).
// Round-robin priority, one-cycle registered responses, saturating conflict counter.
module lns_lut_arbiter #(
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_sel,
  input  logic [5:0]              req_z0,
  input  logic [5:0]              req_z1,
  output logic                    lut_sel,
  output logic [5:0]              lut_z,
  input  logic signed [10:0]      lut_out,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic signed [10:0]      rsp_data0,
  output logic signed [10:0]      rsp_data1,
  output logic [CNT_W-1:0]        conflict_cnt,
  output logic                    busy
);

  logic                   ptr_q, ptr_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic signed [10:0]     rsp_data0_q, rsp_data0_d;
  logic signed [10:0]     rsp_data1_q, rsp_data1_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [1:0]             elig;
  logic [1:0]             grant;
  logic                   g_sel;
  logic [5:0]             g_z;

  // A requester whose previous result is still unread cannot be granted.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;

    g_sel = 1'b0;
    g_z   = '0;
    if (grant[0]) begin
      g_sel = req_sel[0];
      g_z   = req_z0;
    end else if (grant[1]) begin
      g_sel = req_sel[1];
      g_z   = req_z1;
    end
  end

  assign req_ready = grant;
  assign lut_sel   = g_sel;
  // The coarse table has only 32 entries, so the top index bit is forced low.
  assign lut_z     = g_sel ? g_z : {1'b0, g_z[4:0]};

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    cnt_d       = cnt_q;

    if (grant[0]) ptr_d = 1'b1;
    if (grant[1]) ptr_d = 1'b0;

    if (grant[0]) begin
      rsp_valid_d[0] = 1'b1;
      rsp_data0_d    = lut_out;
    end else if (rsp_ready[0]) begin
      rsp_valid_d[0] = 1'b0;
    end

    if (grant[1]) begin
      rsp_valid_d[1] = 1'b1;
      rsp_data1_d    = lut_out;
    end else if (rsp_ready[1]) begin
      rsp_valid_d[1] = 1'b0;
    end

    if (elig == 2'b11 && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q       <= PRIO_INIT[0];
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data0    = rsp_data0_q;
  assign rsp_data1    = rsp_data1_q;
  assign conflict_cnt = cnt_q;
  assign busy         = (|req_valid) | (|rsp_valid_q);

endmodule
